// File: rtl/tree_sum_accum_pkg.sv
// ---------------------------------------------------------------------------
// tree_sum_accum_pkg
// Shared definitions for the tree-sum accumulator slice:
//   state_t    - accumulator FSM states (IDLE / ACCUM / HOLD)
//   calc_in_w  - width of the upstream adder-tree sum for a given leaf count
//                and per-leaf operand width
// No ports; imported by tree_sum_accum.
// Related build macro: TREE_SUM_ACCUM_SATURATE_EN (used by tree_sum_acc_add).
// ---------------------------------------------------------------------------
package tree_sum_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // An adder tree over tree_size leaves grows the operand by log2(leaves)
   // bits; the extra bit leaves headroom for the upstream signed/unsigned mix.
   function automatic int calc_in_w(input int tree_size, input int data_size);
      return data_size + $clog2(tree_size) + 1;
   endfunction

endpackage

// File: rtl/tree_sum_acc_add.sv
// ---------------------------------------------------------------------------
// tree_sum_acc_add
// Combinational ACC_W-bit unsigned adder used by the accumulator.
// Ports:
//   a      [ACC_W-1:0] in  - current accumulator value
//   b      [ACC_W-1:0] in  - zero-extended incoming tree sum
//   sum    [ACC_W-1:0] out - a + b, wrapped or clamped (see macro)
//   carry              out - carry-out of the raw ACC_W-bit add
// Build macro TREE_SUM_ACCUM_SATURATE_EN:
//   defined   - sum clamps to all-ones whenever the add carries out
//   undefined - sum wraps modulo 2^ACC_W
// ---------------------------------------------------------------------------
module tree_sum_acc_add #(
   parameter int ACC_W = 24
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] raw;

   // One extra bit on the add captures the carry-out without a separate compare.
   assign raw   = {1'b0, a} + {1'b0, b};
   assign carry = raw[ACC_W];

`ifdef TREE_SUM_ACCUM_SATURATE_EN
   // Once the accumulator sits at all-ones any further non-zero add carries
   // again, so a saturated frame stays pinned at all-ones by itself.
   assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/tree_sum_accum.sv
// ---------------------------------------------------------------------------
// tree_sum_accum
// Accumulates a frame of adder-tree sums (valid/ready beats, in_last closes
// the frame) and presents the frame total, beat count and overflow flag on a
// valid/ready result port. Input is stalled while a result is held.
// Ports:
//   clk                    in  - rising-edge clock
//   rst_n                  in  - asynchronous active-low reset
//   in_valid / in_ready    in/out - beat handshake
//   in_sum   [IN_W-1:0]    in  - unsigned tree output
//   in_last                in  - beat closes the frame
//   out_valid / out_ready  out/in - result handshake
//   out_sum  [ACC_W-1:0]   out - frame total
//   out_count[CNT_W-1:0]   out - beats in frame (saturating)
//   out_ovf                out - frame overflowed ACC_W
// Build macro TREE_SUM_ACCUM_SATURATE_EN selects clamping (defined) or
// wrapping (undefined) of the accumulator on overflow.
// ---------------------------------------------------------------------------
module tree_sum_accum
   import tree_sum_accum_pkg::*;
#(
   parameter  int TREE_SIZE = 8,
   parameter  int DATA_SIZE = 8,
   parameter  int ACC_W     = 24,
   parameter  int CNT_W     = 8,
   localparam int IN_W      = calc_in_w(TREE_SIZE, DATA_SIZE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;
   logic             beat;

   // Ready is purely a function of state, so it is high throughout reset
   // (state forced to IDLE) and low for the whole of HOLD, including the
   // cycle in which the result is taken.
   assign in_ready = (state != HOLD);
   assign beat     = in_valid && in_ready;

   // The count sticks at all-ones rather than wrapping back to a small value.
   assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
   assign ovf_next = ovf | add_carry;

   tree_sum_acc_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a     (acc),
      .b     (ACC_W'(in_sum)),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // Frame FSM. The accepted last beat is folded into the result registers
   // on the same edge, so out_valid rises exactly one cycle after it; the
   // running state is cleared only when the consumer takes the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (beat) begin
                  acc <= add_sum;
                  cnt <= cnt_next;
                  ovf <= ovf_next;
                  if (in_last) begin
                     out_sum   <= add_sum;
                     out_count <= cnt_next;
                     out_ovf   <= ovf_next;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tree_sum_accum.sv
// ---------------------------------------------------------------------------
// tb_tree_sum_accum
// Directed bench for tree_sum_accum. Three instances share one stimulus bus:
//   dut_a - default parameters (ACC_W 24, CNT_W 8)
//   dut_b - ACC_W 12, to provoke accumulator overflow
//   dut_c - CNT_W 2, to provoke beat-count saturation
// Expected values for dut_b overflow depend on TREE_SUM_ACCUM_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_tree_sum_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic [11:0] in_sum;

   logic        rdy_a, val_a, ovf_a;
   logic [23:0] sum_a;
   logic [7:0]  cnt_a;

   logic        rdy_b, val_b, ovf_b;
   logic [11:0] sum_b;
   logic [7:0]  cnt_b;

   logic        rdy_c, val_c, ovf_c;
   logic [23:0] sum_c;
   logic [1:0]  cnt_c;

   int assert_count = 0;
   int fail_count   = 0;

`ifdef TREE_SUM_ACCUM_SATURATE_EN
   localparam logic [31:0] OVF12_SUM = 32'd4095;
`else
   localparam logic [31:0] OVF12_SUM = 32'd104;
`endif

   always #5 clk = ~clk;

   tree_sum_accum u_dut_a (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (rdy_a), .in_sum (in_sum), .in_last (in_last),
      .out_valid (val_a), .out_ready (out_ready), .out_sum (sum_a),
      .out_count (cnt_a), .out_ovf (ovf_a)
   );

   tree_sum_accum #(.ACC_W (12)) u_dut_b (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (rdy_b), .in_sum (in_sum), .in_last (in_last),
      .out_valid (val_b), .out_ready (out_ready), .out_sum (sum_b),
      .out_count (cnt_b), .out_ovf (ovf_b)
   );

   tree_sum_accum #(.CNT_W (2)) u_dut_c (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (rdy_c), .in_sum (in_sum), .in_last (in_last),
      .out_valid (val_c), .out_ready (out_ready), .out_sum (sum_c),
      .out_count (cnt_c), .out_ovf (ovf_c)
   );

   // One comparison: counts it, and on a miss counts the failure and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Present one beat for a single edge, then drop valid again.
   task automatic applyStimulus(input logic [11:0] value, input logic last);
      in_valid = 1'b1;
      in_sum   = value;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_sum   = '0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_sum    = '0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_in_ready", {31'd0, rdy_a}, 32'd1);
      checkOutput("rst_out_valid", {31'd0, val_a}, 32'd0);
      checkOutput("rst_out_sum", {8'd0, sum_a}, 32'd0);
      checkOutput("rst_out_count", {24'd0, cnt_a}, 32'd0);
      checkOutput("rst_out_ovf", {31'd0, ovf_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three-beat frame with an idle gap before the last beat.
      $display("[TB] frame 10,20,30");
      out_ready = 1'b1;
      applyStimulus(12'd10, 1'b0);
      applyStimulus(12'd20, 1'b0);
      checkOutput("mid_frame_valid", {31'd0, val_a}, 32'd0);
      idleCycles(2);
      applyStimulus(12'd30, 1'b1);
      checkOutput("f1_valid", {31'd0, val_a}, 32'd1);
      checkOutput("f1_sum", {8'd0, sum_a}, 32'd60);
      checkOutput("f1_count", {24'd0, cnt_a}, 32'd3);
      checkOutput("f1_ovf", {31'd0, ovf_a}, 32'd0);
      checkOutput("f1_in_ready_hold", {31'd0, rdy_a}, 32'd0);
      checkOutput("f1_sum_acc12", {20'd0, sum_b}, 32'd60);
      checkOutput("f1_count_cnt2", {30'd0, cnt_c}, 32'd3);
      idleCycles(1);
      checkOutput("f1_valid_after_hs", {31'd0, val_a}, 32'd0);
      checkOutput("f1_in_ready_after_hs", {31'd0, rdy_a}, 32'd1);

      // Single-beat frame goes straight from IDLE to HOLD.
      $display("[TB] single beat 7");
      applyStimulus(12'd7, 1'b1);
      checkOutput("f2_valid", {31'd0, val_a}, 32'd1);
      checkOutput("f2_sum", {8'd0, sum_a}, 32'd7);
      checkOutput("f2_count", {24'd0, cnt_a}, 32'd1);
      idleCycles(1);

      // Consumer stalls for 5 cycles while the producer keeps offering beats.
      $display("[TB] back-pressure");
      out_ready = 1'b0;
      applyStimulus(12'd3, 1'b0);
      applyStimulus(12'd4, 1'b1);
      in_valid = 1'b1;
      in_sum   = 12'd99;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_valid", {31'd0, val_a}, 32'd1);
         checkOutput("stall_sum", {8'd0, sum_a}, 32'd7);
         checkOutput("stall_count", {24'd0, cnt_a}, 32'd2);
         checkOutput("stall_in_ready", {31'd0, rdy_a}, 32'd0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_sum    = '0;
      out_ready = 1'b1;
      idleCycles(1);
      checkOutput("stall_released", {31'd0, val_a}, 32'd0);
      applyStimulus(12'd11, 1'b1);
      checkOutput("after_stall_sum", {8'd0, sum_a}, 32'd11);
      checkOutput("after_stall_count", {24'd0, cnt_a}, 32'd1);
      idleCycles(1);

      // 4000 + 200 = 4200 overflows a 12-bit accumulator.
      $display("[TB] overflow");
      applyStimulus(12'd4000, 1'b0);
      applyStimulus(12'd200, 1'b1);
      checkOutput("ovf12_sum", {20'd0, sum_b}, OVF12_SUM);
      checkOutput("ovf12_flag", {31'd0, ovf_b}, 32'd1);
      checkOutput("ovf24_sum", {8'd0, sum_a}, 32'd4200);
      checkOutput("ovf24_flag", {31'd0, ovf_a}, 32'd0);
      idleCycles(1);
      applyStimulus(12'd1, 1'b1);
      checkOutput("ovf12_cleared_sum", {20'd0, sum_b}, 32'd1);
      checkOutput("ovf12_cleared_flag", {31'd0, ovf_b}, 32'd0);
      idleCycles(1);

      // Five beats of 1: a 2-bit count saturates at 3.
      $display("[TB] count saturation");
      for (int i = 0; i < 4; i++) applyStimulus(12'd1, 1'b0);
      applyStimulus(12'd1, 1'b1);
      checkOutput("cnt2_count", {30'd0, cnt_c}, 32'd3);
      checkOutput("cnt2_sum", {8'd0, sum_c}, 32'd5);
      checkOutput("cnt8_count", {24'd0, cnt_a}, 32'd5);
      idleCycles(1);

      // Asynchronous reset in the middle of a frame.
      $display("[TB] mid-frame reset");
      applyStimulus(12'd1, 1'b0);
      applyStimulus(12'd2, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("areset_valid", {31'd0, val_a}, 32'd0);
      checkOutput("areset_sum", {8'd0, sum_a}, 32'd0);
      checkOutput("areset_count", {24'd0, cnt_a}, 32'd0);
      checkOutput("areset_ovf", {31'd0, ovf_a}, 32'd0);
      checkOutput("areset_in_ready", {31'd0, rdy_a}, 32'd1);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_valid", {31'd0, val_a}, 32'd0);
      applyStimulus(12'd5, 1'b1);
      checkOutput("post_reset_sum", {8'd0, sum_a}, 32'd5);
      checkOutput("post_reset_count", {24'd0, cnt_a}, 32'd1);
      idleCycles(1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/tree_sum_accum.md
TREE_SUM_ACCUM -- requirements
Module: tree_sum_accum

Interface
REQ-001 SHALL have parameter TREE_SIZE, default 8: leaf count of the upstream adder tree, a power of 2.
REQ-002 SHALL have parameter DATA_SIZE, default 8: upstream per-leaf operand width.
REQ-003 SHALL have parameter ACC_W, default 24: accumulator and result width, with ACC_W >= IN_W.
REQ-004 SHALL have parameter CNT_W, default 8: beat-counter width.
REQ-005 SHALL have derived constant IN_W = DATA_SIZE + $clog2(TREE_SIZE) + 1, which is the tree sum width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: in_sum is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-010 SHALL have port in_sum, input, IN_W bits: unsigned tree output.
REQ-011 SHALL have port in_last, input, 1 bit: this beat closes the frame.
REQ-012 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port out_sum, output, ACC_W bits: frame total.
REQ-015 SHALL have port out_count, output, CNT_W bits: number of beats in the frame.
REQ-016 SHALL have port out_ovf, output, 1 bit: the frame overflowed ACC_W.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-018 SHALL count a beat as accepted when in_valid && in_ready at a rising clk edge.
REQ-019 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in HOLD, including the cycle in which the output handshake completes.
REQ-020 SHALL, on an accepted beat in IDLE or ACCUM, add zero-extended in_sum to acc and increment cnt.
REQ-021 SHALL move IDLE -> ACCUM on an accepted beat with in_last = 0.
REQ-022 SHALL, on an accepted beat with in_last = 1 in IDLE or ACCUM, load out_sum, out_count and out_ovf with values that include that beat, and enter HOLD.
REQ-023 SHALL assert out_valid exactly 1 cycle after the accepted last beat, so that a single-beat frame gives IDLE -> HOLD.
REQ-024 SHALL hold out_valid, out_sum, out_count and out_ovf stable in HOLD until out_valid && out_ready.
REQ-025 SHALL, on the output handshake, clear acc, cnt and the ovf flag, deassert out_valid, and enter IDLE on the next cycle.
REQ-026 SHALL saturate cnt at 2^CNT_W-1 and never wrap it.
REQ-027 SHALL, on carry-out from the ACC_W-bit add, set the sticky ovf flag; acc behaviour is governed by the Configuration section.
REQ-028 SHALL hold all state when in_valid = 0, allowing idle gaps mid-frame.
REQ-029 SHALL ignore out_ready while out_valid = 0.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously force: state = IDLE, acc = 0, cnt = 0, ovf = 0, out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0.
REQ-031 SHALL drive in_ready = 1 during reset and after reset.
REQ-032 SHALL discard a partial frame or a held result on reset mid-operation, with no output for it after release.

Configuration
REQ-033 SHALL use the macro TREE_SUM_ACCUM_SATURATE_EN.
REQ-034 SHALL, when TREE_SUM_ACCUM_SATURATE_EN is defined, clamp acc on overflow to all-ones, and clamp further adds in the same frame to all-ones as well.
REQ-035 SHALL, when TREE_SUM_ACCUM_SATURATE_EN is undefined, wrap acc modulo 2^ACC_W.
REQ-036 SHALL set out_ovf on overflow whether or not TREE_SUM_ACCUM_SATURATE_EN is defined.

Structure
REQ-037 SHALL place the state enum (IDLE/ACCUM/HOLD) and a function computing IN_W from TREE_SIZE and DATA_SIZE in package tree_sum_accum_pkg.
REQ-038 SHALL contain one sub-module, tree_sum_acc_add: a combinational ACC_W adder returning sum and carry, with saturation selected by the macro.
REQ-039 SHALL keep all registers in tree_sum_accum.

Verification
REQ-040 SHALL cover: beats 10, 20, 30 with last on 30, out_ready = 1 -> out_valid 1 cycle after the last beat, out_sum = 60, out_count = 3, out_ovf = 0.
REQ-041 SHALL cover: a single beat 7 with last -> out_sum = 7, out_count = 1, HOLD entered directly from IDLE.
REQ-042 SHALL cover: out_ready held 0 for 5 cycles after the result -> outputs stable, in_ready = 0, in_valid stimulus ignored; after out_ready = 1, the next frame starts from acc = 0.
REQ-043 SHALL cover: ACC_W = 12, beats 4000 and 200 with last -> macro undefined: out_sum = 104, out_ovf = 1; macro defined: out_sum = 4095, out_ovf = 1.
REQ-044 SHALL cover: 2 beats accepted then rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately; a following frame of 5 with last gives out_sum = 5, out_count = 1.
REQ-045 SHALL cover: CNT_W = 2 with 5 beats of 1 and last -> out_count = 3 (saturated) and out_sum = 5.
